// File: rtl/countdown_timer.sv
// Loadable 8-bit down-counter with tick prescaler, run/pause/done FSM and HEX1:HEX0 display.
// Define AUTO_RELOAD_EN for periodic mode (reload on terminal tick, one-cycle Done pulse).
module countdown_timer #(
  parameter int DIV = 1
) (
  input  logic       Clock,
  input  logic       Clear_b,
  input  logic       Load,
  input  logic [7:0] LoadValue,
  input  logic       Start,
  input  logic       Pause,
  output logic [7:0] CounterValue,
  output logic       Busy,
  output logic       Done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state;
  logic [7:0]      reload_value;
  logic [PW-1:0]   prescaler;
  logic            tick;
  logic [1:0][6:0] hex_digits;

  assign tick = (prescaler == PRESC_LAST);

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      state        <= IDLE;
      CounterValue <= 8'd0;
      reload_value <= 8'd0;
      prescaler    <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else if (Load) begin
      state        <= IDLE;
      CounterValue <= LoadValue;
      reload_value <= LoadValue;
      prescaler    <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
`ifdef AUTO_RELOAD_EN
      Done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start && CounterValue != 8'd0) begin
            state     <= RUN;
            prescaler <= '0;
            Busy      <= 1'b1;
          end
        end
        RUN: begin
          if (Pause) begin
            state <= PAUSED;
          end else if (tick) begin
            prescaler <= '0;
            // <= 1 rather than == 1 so the count can never wrap past zero
            if (CounterValue <= 8'd1) begin
`ifdef AUTO_RELOAD_EN
              CounterValue <= reload_value;
              Done         <= 1'b1;
`else
              CounterValue <= 8'd0;
              state        <= DONE;
              Done         <= 1'b1;
              Busy         <= 1'b0;
`endif
            end else begin
              CounterValue <= CounterValue - 8'd1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        PAUSED: begin
          // prescaler deliberately kept so the interrupted tick period resumes
          if (Start && !Pause) state <= RUN;
        end
        DONE: begin
          if (Start && reload_value != 8'd0) begin
            state        <= RUN;
            CounterValue <= reload_value;
            prescaler    <= '0;
            Done         <= 1'b0;
            Busy         <= 1'b1;
          end
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_hex
    assign hex_digits[gi] = seg7(CounterValue[gi*4 +: 4]);
  end

  assign HEX0 = hex_digits[0];
  assign HEX1 = hex_digits[1];

endmodule

// File: tb/tb_countdown_timer.sv
// Drives a DIV=1 and a DIV=4 countdown_timer in parallel and checks both against
// an elapsed-time model of the counter; honours AUTO_RELOAD_EN like the design.
module tb_countdown_timer;

  logic            Clock = 1'b0;
  logic            Clear_b;
  logic            Load;
  logic [7:0]      LoadValue;
  logic            Start;
  logic            Pause;
  logic [1:0][7:0] cv;
  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0][6:0] hex0;
  logic [1:0][6:0] hex1;

  int checks = 0;
  int errors = 0;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
  int divs      [2] = '{1, 4};
  int m_state   [2];
  int m_base    [2];
  int m_reload  [2];
  int m_elapsed [2];
  bit m_done    [2];

  always #5 Clock = ~Clock;

  countdown_timer #(.DIV(1)) u_div1 (
    .Clock(Clock), .Clear_b(Clear_b), .Load(Load), .LoadValue(LoadValue),
    .Start(Start), .Pause(Pause), .CounterValue(cv[0]), .Busy(busy[0]),
    .Done(done[0]), .HEX0(hex0[0]), .HEX1(hex1[0])
  );

  countdown_timer #(.DIV(4)) u_div4 (
    .Clock(Clock), .Clear_b(Clear_b), .Load(Load), .LoadValue(LoadValue),
    .Start(Start), .Pause(Pause), .CounterValue(cv[1]), .Busy(busy[1]),
    .Done(done[1]), .HEX0(hex0[1]), .HEX1(hex1[1])
  );

  function automatic logic [6:0] hexpat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Displayed count follows from how many whole DIV periods have elapsed in RUN.
  function automatic int exp_cnt(input int i);
    int periods;
    if (m_state[i] == S_IDLE) return m_base[i];
    if (m_state[i] == S_DONE) return 0;
    periods = m_elapsed[i] / divs[i];
`ifdef AUTO_RELOAD_EN
    return m_reload[i] - (periods % m_reload[i]);
`else
    return m_base[i] - periods;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE; m_base[i] = 0; m_reload[i] = 0;
      m_elapsed[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit ld, input int lv, input bit st, input bit ps);
    for (int i = 0; i < 2; i++) begin
      if (ld) begin
        m_state[i] = S_IDLE; m_base[i] = lv; m_reload[i] = lv;
        m_elapsed[i] = 0; m_done[i] = 1'b0;
      end else begin
`ifdef AUTO_RELOAD_EN
        m_done[i] = 1'b0;
`endif
        case (m_state[i])
          S_IDLE: if (st && m_base[i] != 0) begin m_state[i] = S_RUN; m_elapsed[i] = 0; end
          S_RUN: begin
            if (ps) m_state[i] = S_PAUSED;
            else begin
              m_elapsed[i]++;
`ifdef AUTO_RELOAD_EN
              if (m_elapsed[i] % (m_reload[i] * divs[i]) == 0) m_done[i] = 1'b1;
`else
              if (m_elapsed[i] == m_base[i] * divs[i]) begin
                m_state[i] = S_DONE; m_done[i] = 1'b1;
              end
`endif
            end
          end
          S_PAUSED: if (st && !ps) m_state[i] = S_RUN;
          default: if (st && m_reload[i] != 0) begin
            m_state[i] = S_RUN; m_base[i] = m_reload[i];
            m_elapsed[i] = 0; m_done[i] = 1'b0;
          end
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    for (int i = 0; i < 2; i++) begin
      c = exp_cnt(i);
      chk($sformatf("%s cnt[%0d]", tag, i), 32'(cv[i]), 32'(c));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(busy[i]),
          32'(m_state[i] == S_RUN || m_state[i] == S_PAUSED));
      chk($sformatf("%s done[%0d]", tag, i), 32'(done[i]), 32'(m_done[i]));
      chk($sformatf("%s hex0[%0d]", tag, i), 32'(hex0[i]), 32'(hexpat(c % 16)));
      chk($sformatf("%s hex1[%0d]", tag, i), 32'(hex1[i]), 32'(hexpat(c / 16)));
    end
  endtask

  task automatic step(input string tag, input bit ld, input logic [7:0] lv,
                      input bit st, input bit ps);
    Load = ld; LoadValue = lv; Start = st; Pause = ps;
    @(posedge Clock);
    #1;
    model_edge(ld, int'(lv), st, ps);
    check_all(tag);
    $display("step %-10s ld=%0b lv=%02h st=%0b ps=%0b -> cnt1=%02h cnt4=%02h done=%b busy=%b",
             tag, ld, lv, st, ps, cv[0], cv[1], done, busy);
  endtask

  task automatic async_reset(input string tag);
    #2 Clear_b = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge Clock);
    #1;
    check_all(tag);
    Clear_b = 1'b1;
  endtask

  initial begin
    Clear_b = 1'b0; Load = 1'b0; LoadValue = 8'h00; Start = 1'b0; Pause = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    model_reset();
    check_all("reset");
    Clear_b = 1'b1;

    // asynchronous clear while counting (DIV=4 instance still shows 0x37)
    step("ld37", 1'b1, 8'h37, 1'b0, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    step("run", 1'b0, 8'h00, 1'b0, 1'b0);
    step("run", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst cnt4", 32'(cv[1]), 32'h37);
    async_reset("async_rst");

    // one-shot sequence on DIV=1
    step("ld03", 1'b1, 8'h03, 1'b0, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    step("e1", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("os e1 cnt", 32'(cv[0]), 32'd2);
    step("e2", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("os e2 cnt", 32'(cv[0]), 32'd1);
    chk("os e2 hex0", 32'(hex0[0]), 32'(7'b1111001));
    step("e3", 1'b0, 8'h00, 1'b0, 1'b0);
`ifndef AUTO_RELOAD_EN
    chk("os e3 cnt", 32'(cv[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step("hold", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("os done held", 32'(done[0]), 32'd1);
    end
`endif

    // prescaler with pause on DIV=4
    step("ld02", 1'b1, 8'h02, 1'b0, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pc1", 1'b0, 8'h00, 1'b0, 1'b0);
    step("pc2", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step("pause", 1'b0, 8'h00, 1'b0, 1'b1);
    step("resume", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step("run", 1'b0, 8'h00, 1'b0, 1'b0);

    // Load beats the terminal tick
    step("ld03", 1'b1, 8'h03, 1'b0, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    step("run", 1'b0, 8'h00, 1'b0, 1'b0);
    step("run", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("prio pre cnt", 32'(cv[0]), 32'd1);
    step("ldA5", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("prio cnt", 32'(cv[0]), 32'hA5);
    chk("prio done", 32'(done[0]), 32'd0);
    chk("prio busy", 32'(busy[0]), 32'd0);
    chk("prio hex1", 32'(hex1[0]), 32'(7'b0001000));
    chk("prio hex0", 32'(hex0[0]), 32'(7'b0010010));

    // zero guard
    step("ld00", 1'b1, 8'h00, 1'b0, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("zero busy", 32'(busy[0]), 32'd0);
    chk("zero cnt", 32'(cv[0]), 32'd0);

`ifdef AUTO_RELOAD_EN
    step("ld02", 1'b1, 8'h02, 1'b0, 1'b0);
    step("start", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step("auto", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("auto busy", 32'(busy[0]), 32'd1);
      chk("auto cnt", 32'(cv[0]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("auto done", 32'(done[0]), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
`endif

    // randomized traffic, small load values so terminal ticks are frequent
    for (int k = 0; k < 3000; k++) begin
      bit ld, st, ps;
      logic [7:0] lv;
      ld = ($urandom_range(0, 39) == 0);
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
      else step("rnd", ld, lv, st, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
